rx_packet_fifo: RTL and testbench
=================================

# rx_packet_fifo

Packet-aware byte FIFO between the USB receive path and the Ethernet transmit path. It buffers bytes of the packet currently being received and exposes them to the reader only after the packet is committed. A packet that ends in error, or that overflows the FIFO, is discarded by rolling the write pointer back to the last committed position. Occupancy and full/empty flags are derived from pointer arithmetic inside the block.

## Interface
- DATA_WIDTH, 8, byte width of stored data
- ADDR_BITS, 4, address width; DEPTH = 2**ADDR_BITS entries (16)

Ports:
- clk  input  1  system clock, all state on rising edge
- n_rst  input  1  asynchronous active-low reset
- clear  input  1  synchronous flush of all pointers and state
- pkt_start  input  1  opens a new packet
- wr_en  input  1  write wr_data into the open packet
- wr_data  input  DATA_WIDTH  byte to write
- pkt_commit  input  1  closes the open packet and makes it readable
- pkt_error  input  1  aborts the open packet and rolls it back
- rd_en  input  1  pop the head byte
- rd_data  output  DATA_WIDTH  head byte, first-word-fall-through
- fifo_full  output  1  tentative occupancy == DEPTH
- fifo_empty  output  1  committed occupancy == 0
- count_out  output  ADDR_BITS+1  committed occupancy, 0..DEPTH
- overflow  output  1  open packet has been dropped for overflow

## Operation
- Pointers are ADDR_BITS+1 bits wide: rd_ptr, cwr_ptr (committed), twr_ptr (tentative). The MSB distinguishes full from empty.
- count_out = cwr_ptr − rd_ptr, computed modulo 2**(ADDR_BITS+1).
- Tentative occupancy = twr_ptr − rd_ptr.
- FSM states:
  - IDLE: no packet open.
  - RECV: packet open, writes accepted.
  - DROP: packet open, overflow occurred, writes discarded.
- IDLE: pkt_start → RECV. wr_en, pkt_commit and pkt_error are ignored.
- RECV:
  - wr_en with !fifo_full: write mem[twr_ptr], twr_ptr+1.
  - wr_en with fifo_full: no write, overflow←1, → DROP.
  - pkt_commit: cwr_ptr←twr_ptr (including a byte written the same cycle), → IDLE.
  - pkt_error: twr_ptr←cwr_ptr, → IDLE. A same-cycle wr_en is discarded.
  - pkt_start with a packet already open: twr_ptr←cwr_ptr, stay RECV. The previous partial packet is dropped.
- DROP:
  - wr_en is ignored.
  - pkt_commit or pkt_error: twr_ptr←cwr_ptr, overflow←0, → IDLE. The packet is never published.
  - pkt_start: same rollback, overflow←0, → RECV.
- Priority within a cycle: clear > pkt_error > pkt_start > pkt_commit > wr_en.
- Read side:
  - rd_en with !fifo_empty: rd_ptr+1.
  - rd_en when empty is ignored; no underflow.
  - Reads see committed data only.
  - A read and a write in the same cycle are both performed.
- clear: all pointers←0, overflow←0, → IDLE.
- Wrap-around: pointers wrap naturally at 2**(ADDR_BITS+1). Storage is indexed by the low ADDR_BITS bits.

## Timing
- Reset (n_rst low, asynchronous): pointers 0, state IDLE.
  - fifo_empty=1, fifo_full=0, count_out=0, overflow=0.
  - rd_data = contents of mem[0]; storage itself is not reset.
- Latency from a committed write to readability:
  - Byte written the cycle before pkt_commit: count_out and fifo_empty update one cycle after the commit edge.
  - Byte written in the same cycle as pkt_commit: also visible one cycle after that edge.
- rd_data is valid in the same cycle fifo_empty=0 and changes the cycle after each accepted rd_en.
- fifo_full, fifo_empty, count_out and overflow are registered-pointer functions: no combinational path from any input.
- Reset mid-packet discards the packet and any data buffered so far.

## Structure
- Package rx_fifo_pkg:
  - fifo_state_t enum {IDLE, RECV, DROP}.
  - Default DATA_WIDTH and ADDR_BITS constants.
- Sub-module fifo_regfile holds the storage:
  - DEPTH×DATA_WIDTH array with a synchronous write port and an asynchronous read port.
  - No reset on the array.
- The top level holds the pointers, FSM and flag logic.

## Test plan
Parameters DATA_WIDTH=8, ADDR_BITS=4 for all scenarios.

1. Reset check: assert n_rst low mid-operation → fifo_empty=1, fifo_full=0, count_out=0, overflow=0.
2. Commit and drain:
   - pkt_start, write 0x10..0x14 (5 bytes), pkt_commit → count_out=5 one cycle later.
   - Pop 5 bytes → rd_data sequence 0x10..0x14, then fifo_empty=1.
3. Rollback on error:
   - Commit 3 bytes.
   - pkt_start, write 4 bytes, pkt_error → count_out=3, and the 4 bytes are never readable.
   - The next packet's first byte follows the 3rd committed byte.
4. Overflow:
   - pkt_start, write 17 bytes with no reads → fifo_full=1 after the 16th byte, overflow=1 after the 17th.
   - pkt_commit → count_out=0, overflow=0.
5. Wrap-around with concurrent read/write:
   - Run 3 packets of 10 bytes each, reading concurrently.
   - Byte order is preserved across the pointer wrap; count_out never exceeds 16.
6. Simultaneous events:
   - wr_en and pkt_commit in the same cycle → byte included, count_out +1.
   - wr_en and pkt_error in the same cycle → byte discarded.
   - rd_en while empty → no pointer change.
   - clear with data buffered → empty in the next cycle.

Source files
------------

// File: rtl/rx_fifo_pkg.sv
// rtl/rx_fifo_pkg.sv - shared types and default sizes for the packet FIFO
package rx_fifo_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        DROP = 2'd2
    } fifo_state_t;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ADDR_BITS  = 4;

endpackage

// File: rtl/fifo_regfile.sv
// rtl/fifo_regfile.sv - unreset storage array, sync write, async read
module fifo_regfile #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_BITS  = 4
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_BITS-1:0]  waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_BITS-1:0]  raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [0:(1<<ADDR_BITS)-1];

    // Write port: storage is deliberately not reset
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/rx_packet_fifo.sv
// rtl/rx_packet_fifo.sv - packet-aware byte FIFO with commit/rollback
module rx_packet_fifo
    import rx_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_BITS  = DEF_ADDR_BITS
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  clear,
    input  logic                  pkt_start,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  pkt_commit,
    input  logic                  pkt_error,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  fifo_full,
    output logic                  fifo_empty,
    output logic [ADDR_BITS:0]    count_out,
    output logic                  overflow
);

    localparam logic [ADDR_BITS:0] PTR_ONE  = {{ADDR_BITS{1'b0}}, 1'b1};
    localparam logic [ADDR_BITS:0] FULL_CNT = {1'b1, {ADDR_BITS{1'b0}}};

    fifo_state_t        state, state_nxt;
    logic [ADDR_BITS:0] rd_ptr, cwr_ptr, twr_ptr;
    logic [ADDR_BITS:0] cwr_nxt, twr_nxt;
    logic               ovf_nxt;
    logic               mem_we;
    logic [ADDR_BITS:0] tent_cnt;

    // Flags depend only on registered pointers
    assign count_out  = cwr_ptr - rd_ptr;
    assign tent_cnt   = twr_ptr - rd_ptr;
    assign fifo_empty = (count_out == '0);
    assign fifo_full  = (tent_cnt == FULL_CNT);

    fifo_regfile #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_BITS  (ADDR_BITS)
    ) u_regfile (
        .clk   (clk),
        .we    (mem_we),
        .waddr (twr_ptr[ADDR_BITS-1:0]),
        .wdata (wr_data),
        .raddr (rd_ptr[ADDR_BITS-1:0]),
        .rdata (rd_data)
    );

    // Next-state and write-pointer decisions; error > start > commit > write
    always_comb begin
        state_nxt = state;
        cwr_nxt   = cwr_ptr;
        twr_nxt   = twr_ptr;
        ovf_nxt   = overflow;
        mem_we    = 1'b0;
        case (state)
            IDLE: begin
                if (pkt_start) begin
                    twr_nxt   = cwr_ptr;
                    state_nxt = RECV;
                end
            end
            RECV: begin
                if (pkt_error) begin
                    twr_nxt   = cwr_ptr;
                    state_nxt = IDLE;
                end else if (pkt_start) begin
                    // restart drops the partial packet; a same-cycle write is discarded
                    twr_nxt = cwr_ptr;
                end else if (pkt_commit) begin
                    // a byte arriving with the commit is part of the packet
                    if (wr_en && !fifo_full) begin
                        mem_we  = 1'b1;
                        twr_nxt = twr_ptr + PTR_ONE;
                    end
                    cwr_nxt   = twr_nxt;
                    state_nxt = IDLE;
                end else if (wr_en) begin
                    if (!fifo_full) begin
                        mem_we  = 1'b1;
                        twr_nxt = twr_ptr + PTR_ONE;
                    end else begin
                        ovf_nxt   = 1'b1;
                        state_nxt = DROP;
                    end
                end
            end
            DROP: begin
                if (pkt_error || pkt_start || pkt_commit) begin
                    twr_nxt   = cwr_ptr;
                    ovf_nxt   = 1'b0;
                    state_nxt = (!pkt_error && pkt_start) ? RECV : IDLE;
                end
            end
            default: begin
                twr_nxt   = cwr_ptr;
                ovf_nxt   = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

    // Pointer, FSM and overflow registers; clear flushes everything
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state    <= IDLE;
            rd_ptr   <= '0;
            cwr_ptr  <= '0;
            twr_ptr  <= '0;
            overflow <= 1'b0;
        end else if (clear) begin
            state    <= IDLE;
            rd_ptr   <= '0;
            cwr_ptr  <= '0;
            twr_ptr  <= '0;
            overflow <= 1'b0;
        end else begin
            state    <= state_nxt;
            cwr_ptr  <= cwr_nxt;
            twr_ptr  <= twr_nxt;
            overflow <= ovf_nxt;
            if (rd_en && !fifo_empty) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

endmodule

// File: tb/tb_rx_packet_fifo.sv
// tb/tb_rx_packet_fifo.sv - directed self-checking bench for rx_packet_fifo
module tb_rx_packet_fifo;

    logic       tb_clk = 1'b0;
    logic       n_rst;
    logic       clear;
    logic       pkt_start;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       pkt_commit;
    logic       pkt_error;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       fifo_full;
    logic       fifo_empty;
    logic [4:0] count_out;
    logic       overflow;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 tb_clk = ~tb_clk;

    rx_packet_fifo #(
        .DATA_WIDTH (8),
        .ADDR_BITS  (4)
    ) dut (
        .clk        (tb_clk),
        .n_rst      (n_rst),
        .clear      (clear),
        .pkt_start  (pkt_start),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .pkt_commit (pkt_commit),
        .pkt_error  (pkt_error),
        .rd_en      (rd_en),
        .rd_data    (rd_data),
        .fifo_full  (fifo_full),
        .fifo_empty (fifo_empty),
        .count_out  (count_out),
        .overflow   (overflow)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // advance one clock; inputs change and outputs are sampled 1 ns after the edge
    task automatic cyc();
        @(posedge tb_clk);
        #1;
    endtask

    task automatic idle_in();
        clear = 0; pkt_start = 0; wr_en = 0; wr_data = 0;
        pkt_commit = 0; pkt_error = 0; rd_en = 0;
    endtask

    task automatic send_pkt(input logic [7:0] base, input int n);
        pkt_start = 1; cyc(); pkt_start = 0;
        for (int i = 0; i < n; i++) begin
            wr_en = 1; wr_data = base + 8'(i); cyc();
        end
        wr_en = 0; pkt_commit = 1; cyc(); pkt_commit = 0;
    endtask

    task automatic pop_expect(input string tag, input logic [7:0] exp);
        chk(tag, {24'd0, rd_data}, {24'd0, exp});
        rd_en = 1; cyc(); rd_en = 0;
    endtask

    initial begin
        int rd_idx;
        int wr_idx;
        idle_in();
        n_rst = 0;
        #12;
        n_rst = 1;
        cyc();

        // 1: reset mid-packet
        chk("rst_empty", {31'd0, fifo_empty}, 32'd1);
        send_pkt(8'hA0, 2);
        chk("pre_rst_count", {27'd0, count_out}, 32'd2);
        pkt_start = 1; cyc(); pkt_start = 0;
        wr_en = 1; wr_data = 8'hAA; cyc(); wr_en = 0;
        #2 n_rst = 0;
        #1;
        chk("rst_empty2", {31'd0, fifo_empty}, 32'd1);
        chk("rst_full", {31'd0, fifo_full}, 32'd0);
        chk("rst_count", {27'd0, count_out}, 32'd0);
        chk("rst_ovf", {31'd0, overflow}, 32'd0);
        cyc();
        n_rst = 1;
        cyc();

        // 2: commit and drain
        send_pkt(8'h10, 5);
        chk("c2_count", {27'd0, count_out}, 32'd5);
        chk("c2_nempty", {31'd0, fifo_empty}, 32'd0);
        for (int i = 0; i < 5; i++) pop_expect("c2_data", 8'h10 + 8'(i));
        chk("c2_empty", {31'd0, fifo_empty}, 32'd1);

        // 3: rollback on error
        send_pkt(8'h20, 3);
        pkt_start = 1; cyc(); pkt_start = 0;
        for (int i = 0; i < 4; i++) begin
            wr_en = 1; wr_data = 8'h30 + 8'(i); cyc();
        end
        wr_en = 0;
        chk("e3_hidden", {27'd0, count_out}, 32'd3);
        pkt_error = 1; cyc(); pkt_error = 0;
        chk("e3_count", {27'd0, count_out}, 32'd3);
        send_pkt(8'h40, 1);
        chk("e3_count2", {27'd0, count_out}, 32'd4);
        pop_expect("e3_d0", 8'h20);
        pop_expect("e3_d1", 8'h21);
        pop_expect("e3_d2", 8'h22);
        pop_expect("e3_d3", 8'h40);
        chk("e3_empty", {31'd0, fifo_empty}, 32'd1);

        // 4: overflow
        pkt_start = 1; cyc(); pkt_start = 0;
        for (int i = 0; i < 16; i++) begin
            wr_en = 1; wr_data = 8'h80 + 8'(i); cyc();
            if (i == 14) chk("o4_notfull15", {31'd0, fifo_full}, 32'd0);
        end
        chk("o4_full", {31'd0, fifo_full}, 32'd1);
        chk("o4_noovf", {31'd0, overflow}, 32'd0);
        wr_data = 8'hFF; cyc(); wr_en = 0;
        chk("o4_ovf", {31'd0, overflow}, 32'd1);
        chk("o4_cnt0", {27'd0, count_out}, 32'd0);
        pkt_commit = 1; cyc(); pkt_commit = 0;
        chk("o4_count", {27'd0, count_out}, 32'd0);
        chk("o4_ovf_clr", {31'd0, overflow}, 32'd0);
        chk("o4_full_clr", {31'd0, fifo_full}, 32'd0);

        // 5: three 10-byte packets with concurrent reads across the wrap
        rd_idx = 0;
        wr_idx = 0;
        for (int p = 0; p < 3; p++) begin
            for (int c = 0; c < 12; c++) begin
                pkt_start  = (c == 0);
                wr_en      = (c >= 1 && c <= 10);
                wr_data    = 8'h50 + 8'(wr_idx);
                pkt_commit = (c == 11);
                rd_en      = !fifo_empty;
                if (!fifo_empty) begin
                    chk("w5_data", {24'd0, rd_data}, {24'd0, 8'h50 + 8'(rd_idx)});
                    rd_idx++;
                end
                if (c >= 1 && c <= 10) wr_idx++;
                cyc();
                chk("w5_cnt_le16", {31'd0, (count_out <= 5'd16)}, 32'd1);
            end
        end
        idle_in();
        for (int k = 0; k < 40 && !fifo_empty; k++) begin
            chk("w5_data", {24'd0, rd_data}, {24'd0, 8'h50 + 8'(rd_idx)});
            rd_idx++;
            rd_en = 1; cyc(); rd_en = 0;
        end
        chk("w5_total", rd_idx, 32'd30);
        chk("w5_empty", {31'd0, fifo_empty}, 32'd1);
        chk("w5_ovf", {31'd0, overflow}, 32'd0);

        // 6: simultaneous events
        pkt_start = 1; cyc(); pkt_start = 0;
        wr_en = 1; wr_data = 8'h60; cyc();
        wr_data = 8'h61; pkt_commit = 1; cyc();
        wr_en = 0; pkt_commit = 0;
        chk("s6_commit_wr", {27'd0, count_out}, 32'd2);
        pkt_start = 1; cyc(); pkt_start = 0;
        wr_en = 1; wr_data = 8'h70; pkt_error = 1; cyc();
        wr_en = 0; pkt_error = 0;
        chk("s6_err_wr", {27'd0, count_out}, 32'd2);
        pop_expect("s6_d0", 8'h60);
        pop_expect("s6_d1", 8'h61);
        rd_en = 1; cyc(); cyc(); rd_en = 0;
        chk("s6_underflow_cnt", {27'd0, count_out}, 32'd0);
        chk("s6_underflow_empty", {31'd0, fifo_empty}, 32'd1);
        send_pkt(8'h90, 2);
        pop_expect("s6_after_uf", 8'h90);
        chk("s6_pre_clear", {27'd0, count_out}, 32'd1);
        clear = 1; cyc(); clear = 0;
        chk("s6_clear_empty", {31'd0, fifo_empty}, 32'd1);
        chk("s6_clear_cnt", {27'd0, count_out}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
